// File: rtl/reduceron_trace_monitor.sv
// Purpose : trace monitor for a Reduceron-style core. It captures IO writes, GC start/end,
//           heap-pointer changes and completion as timestamped events, and presents them
//           on a valid/ready output through a small FIFO.
// Latency : an event sampled at edge N is enqueued at edge N+1, so ev_valid rises in the
//           cycle after N+1 (empty FIFO, no contention).
// Backpressure: while ev_ready is low, events wait in per-kind pending latches and then in
//           the FIFO. An event that finds its kind's latch still occupied is dropped and
//           counted in overflow_cnt.
//
// Ports (clock domain: clock, synchronous active-high reset):
//   clock, reset                 clock and synchronous reset
//   result, state, heap          core status buses (tag = result[2:0], GC flag = state[GC_BIT])
//   iowrite, ioaddr, iowd        core IO write strobe, address and data
//   finish                       core completion
//   ev_mask                      per-kind capture enable (bit k = kind k)
//   ev_valid, ev_ready           output handshake for the head event
//   ev_kind, ev_time, ev_a, ev_b head event fields
//   overflow_cnt                 saturating count of dropped events
//   done                         a FINISH event has been consumed

// Generic synchronous FIFO.
// Purpose : stores DEPTH entries of width W. dout shows the head entry.
// Latency : a pushed entry appears at dout in the cycle after the push edge.
// Backpressure: the caller must not push when full unless it also pops in the same cycle,
//           and must not pop when empty.
module rtm_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Pointers carry one extra wrap bit so that full and empty can be told apart.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // When full, the push slot is the head slot. Pushing and popping together overwrites
   // the entry that is leaving, which is correct.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module reduceron_trace_monitor #(
   parameter int DATA_W  = 16,
   parameter int STATE_W = 7,
   parameter int GC_BIT  = 5,
   parameter int HEAP_W  = 13,
   parameter int IO_AW   = 13,
   parameter int IO_DW   = 13,
   parameter int PAY_W   = 16,
   parameter int TS_W    = 32,
   parameter int DEPTH   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DATA_W-1:0]  result,
   input  logic [STATE_W-1:0] state,
   input  logic [HEAP_W-1:0]  heap,
   input  logic               iowrite,
   input  logic [IO_AW-1:0]   ioaddr,
   input  logic [IO_DW-1:0]   iowd,
   input  logic               finish,
   input  logic [4:0]         ev_mask,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [2:0]         ev_kind,
   output logic [TS_W-1:0]    ev_time,
   output logic [PAY_W-1:0]   ev_a,
   output logic [PAY_W-1:0]   ev_b,
   output logic [15:0]        overflow_cnt,
   output logic               done
);
   localparam int NK = 5;   // number of event kinds

   localparam logic [2:0] K_IOWR   = 3'd0;
   localparam logic [2:0] K_HEAP   = 3'd3;
   localparam logic [2:0] K_FINISH = 3'd4;

   typedef struct packed {
      logic [2:0]       kind;
      logic [TS_W-1:0]  tstamp;
      logic [PAY_W-1:0] a;
      logic [PAY_W-1:0] b;
   } ev_t;

   // Registered state.
   logic [TS_W-1:0]   ts;
   logic              prev_gc;
   logic [HEAP_W-1:0] prev_heap;
   logic              fin_seen;
   logic [NK-1:0]     pend;
   ev_t               lat [NK];

   // Combinational signals.
   logic [NK-1:0] det;
   logic [NK-1:0] cap;
   ev_t           new_ev [NK];
   logic          gc_now;
   logic          sel_vld;
   logic [NK-1:0] sel_oh;
   ev_t           sel_ev;
   logic          push;
   logic          pop;
   logic [NK-1:0] free;
   logic [NK-1:0] load;
   logic [NK-1:0] drop;
   logic [2:0]    drop_n;
   logic [16:0]   ovf_sum;
   logic          fifo_full;
   logic          fifo_empty;
   ev_t           head;

   // Only the GC flag of the state bus is observed.
   logic unused_state;
   assign unused_state = ^state;

   assign gc_now = state[GC_BIT];

   // Detection. Once FINISH has been seen, nothing new is captured. The previous-value
   // registers still track their inputs so that nothing depends on that history.
   always_comb begin
      det = '0;
      if (!fin_seen) begin
         det[0] = iowrite;
         det[1] = gc_now & ~prev_gc;
         det[2] = ~gc_now & prev_gc;
         det[3] = (heap != prev_heap);
         det[4] = finish;
      end
      cap = det & ev_mask;
   end

   // Event fields. Narrow sources are zero-extended into the payload width.
   always_comb begin
      for (int k = 0; k < NK; k++) begin
         new_ev[k].kind   = 3'(k);
         new_ev[k].tstamp = ts;
         new_ev[k].a      = '0;
         new_ev[k].b      = '0;
      end
      new_ev[K_IOWR].a   = PAY_W'(ioaddr);
      new_ev[K_IOWR].b   = PAY_W'(iowd);
      new_ev[K_HEAP].a   = PAY_W'(heap);
      new_ev[K_HEAP].b   = PAY_W'(prev_heap);
      new_ev[K_FINISH].a = PAY_W'(result >> 3);
      new_ev[K_FINISH].b = PAY_W'(result[2:0]);
   end

   // Pick the lowest-numbered pending latch. The loop runs downwards, so the last match wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_oh  = '0;
      sel_ev  = lat[0];
      for (int k = NK-1; k >= 0; k--) begin
         if (pend[k]) begin
            sel_vld   = 1'b1;
            sel_oh    = '0;
            sel_oh[k] = 1'b1;
            sel_ev    = lat[k];
         end
      end
   end

   assign ev_valid = ~fifo_empty;
   assign pop      = ev_valid & ev_ready;
   // A full FIFO can still accept an entry when it pops in the same cycle.
   assign push     = sel_vld & (~fifo_full | pop);
   assign free     = push ? sel_oh : '0;

   // A latch that empties this cycle can take a new event at the same edge.
   assign load = cap & (~pend | free);
   assign drop = cap & pend & ~free;

   always_comb begin
      drop_n = '0;
      for (int k = 0; k < NK; k++) begin
         drop_n = drop_n + 3'(drop[k]);
      end
      ovf_sum = {1'b0, overflow_cnt} + 17'(drop_n);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ts           <= '0;
         prev_gc      <= 1'b0;
         prev_heap    <= '0;
         fin_seen     <= 1'b0;
         pend         <= '0;
         overflow_cnt <= '0;
         done         <= 1'b0;
      end else begin
         ts        <= ts + TS_W'(1);
         prev_gc   <= gc_now;
         prev_heap <= heap;
         if (finish) fin_seen <= 1'b1;
         pend      <= (pend & ~free) | load;
         // The count saturates instead of wrapping.
         overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
         if (pop && head.kind == K_FINISH) done <= 1'b1;
      end
   end

   // Latch payloads need no reset because the pend bits qualify them.
   always_ff @(posedge clock) begin
      for (int k = 0; k < NK; k++) begin
         if (load[k]) lat[k] <= new_ev[k];
      end
   end

   rtm_fifo #(
      .W     ($bits(ev_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (sel_ev),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_kind = head.kind;
   assign ev_time = head.tstamp;
   assign ev_a    = head.a;
   assign ev_b    = head.b;
endmodule

// File: tb/tb_reduceron_trace_monitor.sv
module tb_reduceron_trace_monitor;
   logic        clock;
   logic        reset;
   logic [15:0] result;
   logic [6:0]  state;
   logic [12:0] heap;
   logic        iowrite;
   logic [12:0] ioaddr;
   logic [12:0] iowd;
   logic        finish;
   logic [4:0]  ev_mask;
   logic        ev_valid;
   logic        ev_ready;
   logic [2:0]  ev_kind;
   logic [31:0] ev_time;
   logic [15:0] ev_a;
   logic [15:0] ev_b;
   logic [15:0] overflow_cnt;
   logic        done;

   int checks = 0;
   int failures = 0;

   reduceron_trace_monitor dut (
      .clock        (clock),
      .reset        (reset),
      .result       (result),
      .state        (state),
      .heap         (heap),
      .iowrite      (iowrite),
      .ioaddr       (ioaddr),
      .iowd         (iowd),
      .finish       (finish),
      .ev_mask      (ev_mask),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_kind      (ev_kind),
      .ev_time      (ev_time),
      .ev_a         (ev_a),
      .ev_b         (ev_b),
      .overflow_cnt (overflow_cnt),
      .done         (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: a queue for the FIFO and one optional pending event per kind.
   typedef struct {
      int          kind;
      logic [31:0] t;
      logic [15:0] a;
      logic [15:0] b;
   } mev_t;

   mev_t        m_q[$];
   mev_t        m_lat[5];
   bit          m_pend[5];
   logic [31:0] m_ts;
   bit          m_prev_gc;
   logic [12:0] m_prev_heap;
   bit          m_fin;
   int          m_ovf;
   bit          m_done;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit   do_pop;
      bit   was_full;
      bit   moved;
      bit   gc;
      bit   d[5];
      mev_t tmp;
      if (reset) begin
         m_q.delete();
         for (int k = 0; k < 5; k++) m_pend[k] = 0;
         m_ts = 0; m_prev_gc = 0; m_prev_heap = 0; m_fin = 0; m_ovf = 0; m_done = 0;
         return;
      end
      do_pop   = (m_q.size() > 0) && ev_ready;
      was_full = (m_q.size() == 16);
      if (do_pop) begin
         if (m_q[0].kind == 4) m_done = 1;
         tmp = m_q.pop_front();
      end
      moved = 0;
      for (int k = 0; k < 5; k++) begin
         if (m_pend[k] && !moved) begin
            moved = 1;
            if (!was_full || do_pop) begin
               m_q.push_back(m_lat[k]);
               m_pend[k] = 0;
            end
         end
      end
      gc = state[5];
      for (int k = 0; k < 5; k++) d[k] = 0;
      if (!m_fin) begin
         d[0] = iowrite;
         d[1] = gc && !m_prev_gc;
         d[2] = !gc && m_prev_gc;
         d[3] = (heap != m_prev_heap);
         d[4] = finish;
      end
      for (int k = 0; k < 5; k++) begin
         if (d[k] && ev_mask[k]) begin
            if (m_pend[k]) begin
               if (m_ovf < 65535) m_ovf++;
            end else begin
               tmp.kind = k; tmp.t = m_ts; tmp.a = 0; tmp.b = 0;
               if (k == 0) begin tmp.a = 16'(ioaddr); tmp.b = 16'(iowd); end
               if (k == 3) begin tmp.a = 16'(heap); tmp.b = 16'(m_prev_heap); end
               if (k == 4) begin tmp.a = result / 8; tmp.b = result % 8; end
               m_lat[k]  = tmp;
               m_pend[k] = 1;
            end
         end
      end
      if (!m_fin && finish) m_fin = 1;
      m_prev_gc   = gc;
      m_prev_heap = heap;
      m_ts        = m_ts + 1;
   endtask

   task automatic compare_all();
      check("ev_valid", ev_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check("ev_kind", ev_kind, m_q[0].kind);
         check("ev_time", ev_time, m_q[0].t);
         check("ev_a", ev_a, m_q[0].a);
         check("ev_b", ev_b, m_q[0].b);
      end
      check("overflow_cnt", overflow_cnt, m_ovf);
      check("done", done, m_done);
   endtask

   // Apply the current inputs at one rising edge, advance the model, then compare the
   // outputs 1 ns after the edge.
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   logic [31:0] t0;

   initial begin
      reset = 1; result = 0; state = 0; heap = 0; iowrite = 0; ioaddr = 0; iowd = 0;
      finish = 0; ev_mask = 5'h1F; ev_ready = 1;

      // Reset state.
      tick(); tick();
      check("rst_valid", ev_valid, 0);
      check("rst_ovf", overflow_cnt, 0);
      check("rst_done", done, 0);

      // A single IO write, detected at the first edge after reset (ts = 0).
      reset = 0; iowrite = 1; ioaddr = 5; iowd = 9;
      tick();
      iowrite = 0;
      check("iowr_latency_not_yet", ev_valid, 0);
      tick();
      check("iowr_valid", ev_valid, 1);
      check("iowr_kind", ev_kind, 0);
      check("iowr_a", ev_a, 5);
      check("iowr_b", ev_b, 9);
      check("iowr_time", ev_time, 0);
      tick();
      check("iowr_popped", ev_valid, 0);

      // GC start and a heap change at the same edge (ts = 3).
      state = 7'h20; heap = 40;
      tick(); tick();
      check("gcs_kind", ev_kind, 1);
      check("gcs_time", ev_time, 3);
      check("gcs_a", ev_a, 0);
      tick();
      check("heap_kind", ev_kind, 3);
      check("heap_a", ev_a, 40);
      check("heap_b", ev_b, 0);
      check("heap_time", ev_time, 3);
      tick();
      check("pair_drained", ev_valid, 0);

      // Heap capture masked off. A later GC end is still reported.
      ev_mask = 5'b10111; heap = 77;
      tick();
      heap = 12;
      tick(); tick();
      check("mask_no_heap", ev_valid, 0);
      check("mask_ovf", overflow_cnt, 0);
      state = 7'h00;
      tick(); tick();
      check("gce_valid", ev_valid, 1);
      check("gce_kind", ev_kind, 2);
      tick();
      ev_mask = 5'h1F;
      tick();
      check("gce_drained", ev_valid, 0);

      // Overflow: ev_ready low, DEPTH+3 consecutive IO writes.
      t0 = m_ts;
      ev_ready = 0; iowrite = 1;
      for (int i = 0; i < 19; i++) begin
         ioaddr = 13'(i); iowd = 13'(i + 100);
         tick();
      end
      iowrite = 0;
      check("ovf_count", overflow_cnt, 2);
      check("ovf_valid", ev_valid, 1);
      ev_ready = 1;
      for (int i = 0; i < 17; i++) begin
         check("ovf_order_a", ev_a, i);
         check("ovf_order_time", ev_time, t0 + 32'(i));
         tick();
      end
      check("ovf_drained", ev_valid, 0);

      // Random traffic checked against the model.
      for (int i = 0; i < 400; i++) begin
         iowrite  = ($urandom_range(0, 2) == 0);
         ioaddr   = 13'($urandom);
         iowd     = 13'($urandom);
         ev_ready = ($urandom_range(0, 3) != 0);
         ev_mask  = 5'($urandom) | 5'b00001;
         result   = 16'($urandom);
         if ($urandom_range(0, 3) == 0) state = 7'($urandom);
         if ($urandom_range(0, 4) == 0) heap = 13'($urandom);
         tick();
      end
      iowrite = 0; ev_ready = 1; ev_mask = 5'h1F; state = 0; heap = 0;
      for (int i = 0; i < 12; i++) tick();
      check("rand_drained", ev_valid, 0);

      // Reset pulse while the FIFO holds 4 entries.
      ev_ready = 0; iowrite = 1;
      for (int i = 0; i < 5; i++) tick();
      iowrite = 0;
      check("pre_rst_valid", ev_valid, 1);
      reset = 1;
      tick();
      check("mid_rst_valid", ev_valid, 0);
      check("mid_rst_ovf", overflow_cnt, 0);
      reset = 0; ev_ready = 1; iowrite = 1; ioaddr = 3; iowd = 4;
      tick();
      iowrite = 0;
      tick();
      check("post_rst_time", ev_time, 0);
      check("post_rst_a", ev_a, 3);
      tick();

      // Finish: detection stops and done follows the pop.
      result = 16'h0053; finish = 1;
      tick(); tick();
      check("fin_kind", ev_kind, 4);
      check("fin_a", ev_a, 10);
      check("fin_b", ev_b, 3);
      check("fin_done_before", done, 0);
      iowrite = 1; ioaddr = 7;
      tick();
      check("fin_done", done, 1);
      iowrite = 0;
      tick();
      iowrite = 1;
      tick(); tick();
      check("fin_ignored", ev_valid, 0);
      check("fin_done_held", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
